// File: rtl/ship_placement.sv
// ship_placement: records player ships from the cursor, then fills the CPU map from an LFSR; SHIP_PLACEMENT_UNDO_EN adds an undo input
module ship_placement #(
  parameter int          NUM_SHIPS = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phase,
  input  logic        confirm,
`ifdef SHIP_PLACEMENT_UNDO_EN
  input  logic        undo,
`endif
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [27:0] pships,
  output logic [27:0] cships,
  output logic [2:0]  ship_count,
  output logic        reject,
  output logic        place_done
);
  typedef enum logic [1:0] {IDLE, PLAYER, CPU_GEN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic conf_q, c_edge, u_edge, clr, valid, occ, do_place, rej, cpu_ok;
  logic [6:0] low;
  logic [1:0] digit;
  logic [2:0] k, cpu_cnt;
  logic [4:0] idx, cand;
  logic [31:0] cx;
  assign c_edge = confirm & ~conf_q;
`ifdef SHIP_PLACEMENT_UNDO_EN
  logic undo_q, do_undo;
  logic [2:0] tp;
  logic [4:0] top;
  logic [NUM_SHIPS*5-1:0] stk;
  assign u_edge = undo & ~undo_q;
  assign tp = ship_count - 3'd1;
  assign top = stk[5*tp +: 5];
  assign do_undo = !clr && state == PLAYER && u_edge && ship_count != 3'd0;
`else
  assign u_edge = 1'b0;
`endif
  always_comb begin
    low = ~seg[6:0];
    digit = an == 4'b1110 ? 2'd0 : an == 4'b1101 ? 2'd1 : an == 4'b1011 ? 2'd2 : 2'd3;
    k = low[0] ? 3'd0 : low[1] ? 3'd1 : low[2] ? 3'd2 : low[3] ? 3'd3 :
        low[4] ? 3'd4 : low[5] ? 3'd5 : 3'd6;
    idx = 5'(digit) * 5'd7 + 5'(k);
    valid = (an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) && seg[7] &&
            low != 7'd0 && (low & (low - 7'd1)) == 7'd0;
    occ = pships[idx];
    cand = lfsr[4:0];
    cx = {4'd0, cships};
    clr = state != IDLE && !phase;
    do_place = !clr && state == PLAYER && c_edge && !u_edge && valid && !occ;
    rej = !clr && state == PLAYER && (u_edge ? ship_count == 3'd0 : c_edge && !(valid && !occ));
    cpu_ok = !clr && state == CPU_GEN && cand < 5'd28 && !cx[cand];
    state_n = clr ? IDLE : state;
    if (!clr)
      case (state)
        IDLE:    state_n = phase ? PLAYER : IDLE;
        PLAYER:  state_n = do_place && ship_count == 3'(NUM_SHIPS - 1) ? CPU_GEN : PLAYER;
        CPU_GEN: state_n = cpu_ok && cpu_cnt == 3'(NUM_SHIPS - 1) ? DONE : CPU_GEN;
        default: state_n = DONE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // the LFSR free-runs in every state so the CPU layout depends on player timing
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lfsr <= LFSR_SEED;
      conf_q <= 1'b0;
      pships <= '0;
      cships <= '0;
      ship_count <= '0;
      cpu_cnt <= '0;
      reject <= 1'b0;
      place_done <= 1'b0;
`ifdef SHIP_PLACEMENT_UNDO_EN
      undo_q <= 1'b0;
      stk <= '0;
`endif
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      conf_q <= confirm;
      reject <= rej;
`ifdef SHIP_PLACEMENT_UNDO_EN
      undo_q <= undo;
      if (do_place) stk[5*ship_count +: 5] <= idx;
      if (do_undo) begin
        pships <= pships & ~(28'd1 << top);
        ship_count <= ship_count - 3'd1;
      end
`endif
      if (clr) begin
        pships <= '0;
        cships <= '0;
        ship_count <= '0;
        cpu_cnt <= '0;
        place_done <= 1'b0;
      end else begin
        if (do_place) begin
          pships <= pships | (28'd1 << idx);
          ship_count <= ship_count + 3'd1;
        end
        if (cpu_ok) begin
          cships <= cships | (28'd1 << cand);
          cpu_cnt <= cpu_cnt + 3'd1;
        end
        if (state == CPU_GEN && state_n == DONE) place_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ship_placement.sv
// tb_ship_placement: table-driven placement vectors with a scoreboard queue plus an LFSR reference for the CPU map
module tb_ship_placement;
  logic clk = 1'b0, rst = 1'b1, phase = 1'b0, confirm = 1'b0;
  logic [3:0] an = 4'hF;
  logic [7:0] seg = 8'hFF;
  logic [27:0] pships, cships;
  logic [2:0] ship_count;
  logic reject, place_done;
`ifdef SHIP_PLACEMENT_UNDO_EN
  logic undo = 1'b0;
`endif
  int checks = 0, failures = 0;

  typedef struct { logic [3:0] an; logic [7:0] seg; logic [27:0] p; logic [2:0] c; logic r; } vec_t;
  typedef struct { logic [27:0] p; logic [2:0] c; logic r; } exp_t;
  vec_t tbl[8];
  exp_t q[$];
  logic [15:0] m_lfsr, lf_last;

  always #5 clk = ~clk;

  ship_placement dut (
    .clk(clk), .rst(rst), .phase(phase), .confirm(confirm),
`ifdef SHIP_PLACEMENT_UNDO_EN
    .undo(undo),
`endif
    .an(an), .seg(seg), .pships(pships), .cships(cships),
    .ship_count(ship_count), .reject(reject), .place_done(place_done)
  );

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // reference generator: one candidate per cycle starting from the LFSR value seen on the first CPU cycle
  function automatic logic [27:0] gen(input logic [15:0] l0);
    logic [27:0] cs = '0;
    logic [15:0] l = l0;
    int n = 0;
    for (int i = 0; i < 1000 && n < 4; i++) begin
      if (l[4:0] < 5'd28 && !cs[l[4:0]]) begin
        cs[l[4:0]] = 1'b1;
        n++;
      end
      l = nxt(l);
    end
    return cs;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= nxt(m_lfsr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_pop;
    exp_t x;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    x = q.pop_front();
    chk("pships", pships, x.p);
    chk("ship_count", ship_count, x.c);
    chk("reject", reject, x.r);
  endtask

  task automatic pulse(input logic [3:0] a, input logic [7:0] s, input exp_t e);
    @(negedge clk);
    an = a;
    seg = s;
    confirm = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    lf_last = m_lfsr;
    compare_pop();
    @(negedge clk);
    confirm = 1'b0;
    @(posedge clk);
    #1;
    chk("reject_one_cycle", reject, 0);
  endtask

`ifdef SHIP_PLACEMENT_UNDO_EN
  task automatic upulse(input logic cf, input logic [3:0] a, input logic [7:0] s, input exp_t e);
    @(negedge clk);
    an = a;
    seg = s;
    confirm = cf;
    undo = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop();
    @(negedge clk);
    confirm = 1'b0;
    undo = 1'b0;
    @(posedge clk);
    #1;
    chk("undo_reject_one_cycle", reject, 0);
  endtask
`endif

  task automatic do_reset;
    rst = 1'b0;
    phase = 1'b0;
    confirm = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    phase = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table;
    foreach (tbl[i]) pulse(tbl[i].an, tbl[i].seg, '{tbl[i].p, tbl[i].c, tbl[i].r});
  endtask

  task automatic wait_done;
    int n = 0;
    while (!place_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("place_done", place_done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] exp_cs;
    int rj;
    tbl[0] = '{4'b1110, 8'hFE, 28'h0000001, 3'd1, 1'b0};
    tbl[1] = '{4'b1110, 8'hFE, 28'h0000001, 3'd1, 1'b1};
    tbl[2] = '{4'b1110, 8'hFC, 28'h0000001, 3'd1, 1'b1};
    tbl[3] = '{4'b1101, 8'hFD, 28'h0000101, 3'd2, 1'b0};
    tbl[4] = '{4'b0111, 8'hBF, 28'h8000101, 3'd3, 1'b0};
    tbl[5] = '{4'b1111, 8'hFE, 28'h8000101, 3'd3, 1'b1};
    tbl[6] = '{4'b1110, 8'h7E, 28'h8000101, 3'd3, 1'b1};
    tbl[7] = '{4'b1011, 8'hEF, 28'h8040101, 3'd4, 1'b0};
    #2;
    rst = 1'b0;
    #1;
    chk("rst_pships", pships, 0);
    chk("rst_cships", cships, 0);
    chk("rst_count", ship_count, 0);
    chk("rst_reject", reject, 0);
    chk("rst_done", place_done, 0);
    do_reset();
    run_table();
    exp_cs = gen(lf_last);
    wait_done();
    chk("cships", cships, exp_cs);
    chk("cships_popcount", $countones(cships), 4);
    chk("pships_final", pships, 28'h8040101);
    pulse(4'b1110, 8'hFB, '{28'h8040101, 3'd4, 1'b0});
    chk("cships_frozen", cships, exp_cs);
    chk("done_held", place_done, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_pships", pships, 0);
    chk("async_cships", cships, 0);
    chk("async_count", ship_count, 0);
    chk("async_done", place_done, 0);
    do_reset();
    run_table();
    wait_done();
    chk("cships_rerun", cships, exp_cs);
    chk("cships_rerun_model", cships, gen(lf_last));
    @(negedge clk);
    phase = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_pships", pships, 0);
    chk("clr_cships", cships, 0);
    chk("clr_count", ship_count, 0);
    chk("clr_done", place_done, 0);
    @(negedge clk);
    phase = 1'b1;
    @(negedge clk);
    pulse(4'b1110, 8'hFE, '{28'h1, 3'd1, 1'b0});
    @(negedge clk);
    an = 4'b1101;
    seg = 8'hFD;
    confirm = 1'b1;
    phase = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_pships", pships, 0);
    chk("prio_count", ship_count, 0);
    chk("prio_reject", reject, 0);
    @(negedge clk);
    confirm = 1'b0;
    phase = 1'b1;
    @(negedge clk);
    @(negedge clk);
    an = 4'b1110;
    seg = 8'hFE;
    confirm = 1'b1;
    rj = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (reject) rj++;
    end
    chk("hold_pships", pships, 28'h1);
    chk("hold_count", ship_count, 1);
    chk("hold_rejects", rj, 0);
    @(negedge clk);
    confirm = 1'b0;
    pulse(4'b1101, 8'hFD, '{28'h101, 3'd2, 1'b0});
    pulse(4'b0111, 8'hBF, '{28'h8000101, 3'd3, 1'b0});
    @(negedge clk);
    an = 4'b1011;
    seg = 8'hEF;
    confirm = 1'b1;
    @(posedge clk);
    #1;
    chk("gen_entry_count", ship_count, 4);
    phase = 1'b0;
    confirm = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_pships", pships, 0);
    chk("drop_cships", cships, 0);
    chk("drop_count", ship_count, 0);
    chk("drop_done", place_done, 0);
    @(negedge clk);
    phase = 1'b1;
    @(negedge clk);
    pulse(4'b1110, 8'hFE, '{28'h1, 3'd1, 1'b0});
`ifdef SHIP_PLACEMENT_UNDO_EN
    pulse(4'b1101, 8'hFD, '{28'h101, 3'd2, 1'b0});
    upulse(1'b0, 4'b1110, 8'hFF, '{28'h1, 3'd1, 1'b0});
    upulse(1'b0, 4'b1110, 8'hFF, '{28'h0, 3'd0, 1'b0});
    upulse(1'b0, 4'b1110, 8'hFF, '{28'h0, 3'd0, 1'b1});
    pulse(4'b1110, 8'hFE, '{28'h1, 3'd1, 1'b0});
    upulse(1'b1, 4'b1101, 8'hFD, '{28'h0, 3'd0, 1'b0});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
